// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, width
// helpers for the bit-timing counters, and the parity check function.
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Widest data word supported; parity is evaluated over a zero-padded word
  localparam int MAX_DATA_BITS = 9;

  // Width of the oversample tick counter
  function automatic int cnt_width(input int oversample);
    return $clog2(oversample);
  endfunction

  // Tick count at which the start bit is sampled (mid start bit)
  function automatic int mid_count(input int oversample);
    return (oversample / 2) - 1;
  endfunction

  // Width of the data bit index
  function automatic int idx_width(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

  // Nonzero when data, received parity bit and sense do not agree
  function automatic logic parity_error(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic                     parity_bit,
                                        input logic                     odd);
    return (^data) ^ parity_bit ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver: two-flop synchroniser on the
// asynchronous rxd line (idle value 1) and rising-edge detection of the
// oversample level from the clock generator.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic reset,
  input  logic sample_clk,
  input  logic rxd,
  output logic rxd_s,
  output logic tick
);

  logic meta_r;
  logic sync_r;
  logic sample_clk_q_r;

  // Two-flop synchroniser; resets to the idle line level
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= rxd;
      sync_r <= meta_r;
    end
  end

  // Delayed copy of sample_clk so each high phase yields exactly one tick
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      sample_clk_q_r <= 1'b0;
    end else begin
      sample_clk_q_r <= sample_clk;
    end
  end

  assign rxd_s = sync_r;
  assign tick  = sample_clk & ~sample_clk_q_r;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start-bit detection, mid-bit sampling of data, optional
// parity and stop bit, and a one-entry valid/ready holding register with
// per-word error flags and a sticky overrun indication.
import uart_pkg::*;

module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 sample_clk,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(OVERSAMPLE);
  localparam int MID   = mid_count(OVERSAMPLE);
  localparam int IDX_W = idx_width(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic             ODD_SENSE = 1'(PARITY_ODD);

  rx_state_e              state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [IDX_W-1:0]       bit_idx_r;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   rxd_prev_r;
  logic                   pe_r;

  logic                   rxd_s;
  logic                   tick_s;
  logic                   commit_s;
  logic                   fe_s;
  logic                   pe_s;
  logic                   hs_s;
  logic [MAX_DATA_BITS-1:0] shift_ext_s;

  uart_rx_sync u_sync (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .sample_clk (sample_clk),
    .rxd        (rxd),
    .rxd_s      (rxd_s),
    .tick       (tick_s)
  );

  // Zero-extend the assembled word for the parity helper
  always_comb begin
    shift_ext_s                = '0;
    shift_ext_s[DATA_BITS-1:0] = shift_r;
  end

  // Word completion strobe and its flags, raised on the stop-bit sample tick
  always_comb begin
    commit_s = 1'b0;
    fe_s     = 1'b0;
    pe_s     = 1'b0;
    if ((state_r == STOP) && tick_s && (cnt_r == CNT_LAST)) begin
      commit_s = 1'b1;
      fe_s     = ~rxd_s;
      pe_s     = (PARITY_EN != 0) ? pe_r : 1'b0;
    end else begin
      commit_s = 1'b0;
      fe_s     = 1'b0;
      pe_s     = 1'b0;
    end
  end

  assign hs_s = rx_valid & rx_ready;
  assign busy = (state_r != IDLE);

  // Receive FSM: bit timing, sampling and word assembly, all tick-paced
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      bit_idx_r  <= '0;
      shift_r    <= '0;
      rxd_prev_r <= 1'b1;
      pe_r       <= 1'b0;
    end else if (tick_s) begin
      rxd_prev_r <= rxd_s;
      case (state_r)
        IDLE: begin
          cnt_r     <= '0;
          bit_idx_r <= '0;
          // Only a high-to-low transition starts a frame, so a held break is ignored
          if (!rxd_s && rxd_prev_r) begin
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (cnt_r == CNT_MID) begin
            cnt_r   <= '0;
            state_r <= rxd_s ? IDLE : DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            shift_r <= {rxd_s, shift_r[DATA_BITS-1:1]};
            if (bit_idx_r == IDX_LAST) begin
              bit_idx_r <= '0;
              state_r   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_idx_r <= bit_idx_r + IDX_ONE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        PARITY: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            pe_r    <= parity_error(shift_ext_s, rxd_s, ODD_SENSE);
            state_r <= STOP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          cnt_r     <= '0;
          bit_idx_r <= '0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Holding register: load on commit when free, otherwise flag overrun; drain on handshake
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit_s) begin
      if (!rx_valid || rx_ready) begin
        rx_data    <= shift_r;
        rx_valid   <= 1'b1;
        frame_err  <= fe_s;
        parity_err <= pe_s;
        // A handshake in this cycle also consumes any pending overrun
        if (hs_s) begin
          overrun <= 1'b0;
        end else begin
          overrun <= overrun;
        end
      end else begin
        overrun <= 1'b1;
      end
    end else if (hs_s) begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_valid <= rx_valid;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: an 8N1 receiver and an 8E1 receiver fed
// from separate serial lines, with expected words queued as frames are sent
// and compared when each word is handed over.
module tb_uart_rx_core;

  localparam int BIT_CYC = 64;   // 16 ticks per bit, one tick every 4 sys_clk cycles

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       sys_clk    = 1'b0;
  logic       reset      = 1'b0;
  logic       sample_clk = 1'b0;
  logic       rxd_a      = 1'b1;
  logic       rxd_p      = 1'b1;
  logic       ready_a    = 1'b1;
  logic       ready_p    = 1'b1;

  logic [7:0] rx_data_a,  rx_data_p;
  logic       rx_valid_a, rx_valid_p;
  logic       frame_err_a, frame_err_p;
  logic       parity_err_a, parity_err_p;
  logic       overrun_a, overrun_p;
  logic       busy_a, busy_p;

  exp_t q_a[$];
  exp_t q_p[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .sample_clk (sample_clk),
    .rxd        (rxd_a),
    .rx_data    (rx_data_a),
    .rx_valid   (rx_valid_a),
    .rx_ready   (ready_a),
    .frame_err  (frame_err_a),
    .parity_err (parity_err_a),
    .overrun    (overrun_a),
    .busy       (busy_a)
  );

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .sample_clk (sample_clk),
    .rxd        (rxd_p),
    .rx_data    (rx_data_p),
    .rx_valid   (rx_valid_p),
    .rx_ready   (ready_p),
    .frame_err  (frame_err_p),
    .parity_err (parity_err_p),
    .overrun    (overrun_p),
    .busy       (busy_p)
  );

  always #5 sys_clk = ~sys_clk;

  // Oversample level: two cycles high, two low
  initial begin
    forever begin
      repeat (2) @(posedge sys_clk);
      #1 sample_clk = ~sample_clk;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit sel, input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.data = d;
    e.fe   = fe;
    e.pe   = pe;
    if (sel) q_p.push_back(e);
    else     q_a.push_back(e);
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rxd_p = v;
    else     rxd_a = v;
    repeat (BIT_CYC) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                            input logic par, input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (use_par) drive_bit(sel, par);
    drive_bit(sel, stop);
  endtask

  task automatic line_high(input bit sel, input int cyc);
    if (sel) rxd_p = 1'b1;
    else     rxd_a = 1'b1;
    repeat (cyc) @(posedge sys_clk);
    #1;
  endtask

  // Bounded wait for rx_valid; a timeout counts as a failed comparison
  task automatic wait_valid(input bit sel, input string tag);
    int k;
    k = 0;
    while (!(sel ? rx_valid_p : rx_valid_a) && (k < 1200)) begin
      @(negedge sys_clk);
      k++;
    end
    check(tag, {31'd0, (sel ? rx_valid_p : rx_valid_a)}, 32'd1);
  endtask

  // Scoreboard for the 8N1 receiver: compare on every handshake
  always @(negedge sys_clk) begin
    if (reset && rx_valid_a && ready_a) begin
      if (q_a.size() == 0) begin
        n_vec++;
        n_miss++;
        $error("FAIL a_unexpected_word: observed %0h expected none", rx_data_a);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_data", {24'd0, rx_data_a}, {24'd0, e.data});
        check("a_frame_err", {31'd0, frame_err_a}, {31'd0, e.fe});
        check("a_parity_err", {31'd0, parity_err_a}, {31'd0, e.pe});
      end
    end
  end

  // Scoreboard for the parity receiver
  always @(negedge sys_clk) begin
    if (reset && rx_valid_p && ready_p) begin
      if (q_p.size() == 0) begin
        n_vec++;
        n_miss++;
        $error("FAIL p_unexpected_word: observed %0h expected none", rx_data_p);
      end else begin
        exp_t e;
        e = q_p.pop_front();
        check("p_data", {24'd0, rx_data_p}, {24'd0, e.data});
        check("p_frame_err", {31'd0, frame_err_p}, {31'd0, e.fe});
        check("p_parity_err", {31'd0, parity_err_p}, {31'd0, e.pe});
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_data", {24'd0, rx_data_a}, 32'd0);
    check("rst_flags", {27'd0, rx_valid_a, frame_err_a, parity_err_a, overrun_a, busy_a}, 32'd0);
    @(posedge sys_clk);
    #1 reset = 1'b1;
    line_high(1'b0, 40);

    // Basic 8N1 frame
    push_exp(1'b0, 8'hA5, 1'b0, 1'b0);
    fork
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        wait_valid(1'b0, "basic_valid");
        check("basic_busy_low", {31'd0, busy_a}, 32'd0);
        check("basic_overrun", {31'd0, overrun_a}, 32'd0);
        @(negedge sys_clk);
        check("basic_valid_pulse", {31'd0, rx_valid_a}, 32'd0);
      end
    join
    line_high(1'b0, BIT_CYC);

    // Glitch: 4 ticks low, then high again
    rxd_a = 1'b0;
    repeat (16) @(posedge sys_clk);
    #1;
    check("glitch_busy", {31'd0, busy_a}, 32'd1);
    line_high(1'b0, 2 * BIT_CYC);
    check("glitch_idle", {31'd0, busy_a}, 32'd0);
    check("glitch_no_word", {31'd0, rx_valid_a}, 32'd0);

    // Bad stop bit, then a held break
    push_exp(1'b0, 8'h3C, 1'b1, 1'b0);
    fork
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
      wait_valid(1'b0, "badstop_valid");
    join
    repeat (3 * BIT_CYC) @(posedge sys_clk);
    #1;
    check("break_no_busy", {31'd0, busy_a}, 32'd0);
    check("break_no_word", {31'd0, rx_valid_a}, 32'd0);
    line_high(1'b0, 2 * BIT_CYC);

    // Parity receiver: correct then wrong even parity for 0x07
    push_exp(1'b1, 8'h07, 1'b0, 1'b0);
    fork
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
      wait_valid(1'b1, "par_ok_valid");
    join
    line_high(1'b1, BIT_CYC);
    push_exp(1'b1, 8'h07, 1'b0, 1'b1);
    fork
      send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      wait_valid(1'b1, "par_bad_valid");
    join
    line_high(1'b1, BIT_CYC);

    // Overrun: two frames back-to-back with the host stalled
    ready_a = 1'b0;
    push_exp(1'b0, 8'h11, 1'b0, 1'b0);
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    line_high(1'b0, 10);
    check("ovr_valid", {31'd0, rx_valid_a}, 32'd1);
    check("ovr_data_kept", {24'd0, rx_data_a}, 32'h11);
    check("ovr_flag", {31'd0, overrun_a}, 32'd1);
    ready_a = 1'b1;
    @(posedge sys_clk);
    #1 ready_a = 1'b0;
    @(negedge sys_clk);
    check("ovr_drained", {31'd0, rx_valid_a}, 32'd0);
    check("ovr_cleared", {31'd0, overrun_a}, 32'd0);
    check("ovr_data_held", {24'd0, rx_data_a}, 32'h11);
    ready_a = 1'b1;
    line_high(1'b0, BIT_CYC);

    // Reset during data bit 3 of 0x5A
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    rxd_a = 1'b1;
    repeat (32) @(posedge sys_clk);
    #1;
    check("midrst_busy_before", {31'd0, busy_a}, 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_data", {24'd0, rx_data_a}, 32'd0);
    check("midrst_flags", {27'd0, rx_valid_a, frame_err_a, parity_err_a, overrun_a, busy_a}, 32'd0);
    check("midrst_p_data", {24'd0, rx_data_p}, 32'd0);
    rxd_a = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1 reset = 1'b1;
    line_high(1'b0, 2 * BIT_CYC);
    push_exp(1'b0, 8'hC3, 1'b0, 1'b0);
    fork
      send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
      begin
        wait_valid(1'b0, "post_rst_valid");
        check("post_rst_overrun", {31'd0, overrun_a}, 32'd0);
      end
    join
    line_high(1'b0, BIT_CYC);

    check("q_a_drained", q_a.size(), 32'd0);
    check("q_p_drained", q_p.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
